// File: rtl/main_menu_pkg.sv
// Shared encodings for the main-menu controller and the VGA renderer that
// consumes the selection index from the metadata word.
package main_menu_pkg;

   localparam int SEL_LSB = 26;
   localparam int SEL_MSB = 28;
   localparam int SEL_W   = SEL_MSB - SEL_LSB + 1;

   typedef enum logic [SEL_W-1:0] {
      OPT_PLAY_1P      = 3'd0,
      OPT_PLAY_ENDLESS = 3'd1,
      OPT_PLAY_2P      = 3'd2,
      OPT_TOP_1P       = 3'd3,
      OPT_TOP_ENDLESS  = 3'd4
   } opt_e;

   typedef enum logic [1:0] {
      MENU    = 2'd0,
      LAUNCH  = 2'd1,
      RUNNING = 2'd2
   } state_e;

   // Button vector bit positions inside the controller.
   localparam int BTN_UP     = 0;
   localparam int BTN_DOWN   = 1;
   localparam int BTN_LEFT   = 2;
   localparam int BTN_RIGHT  = 3;
   localparam int BTN_SELECT = 4;
   localparam int NUM_BTNS   = 5;

endpackage

// File: rtl/button_debouncer.sv
// Synchronizes one raw button, requires DEBOUNCE_CYCLES stable cycles before
// accepting a level change, and emits a registered pulse on each press.
module button_debouncer #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int CNT_W           = 18
) (
   input  logic clock,
   input  logic resetn,
   input  logic raw,
   output logic press
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync2_q;
   logic             stable_q, stable_d;
   logic             prev_q;
   logic             press_q, press_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d    = cnt_q;
      stable_d = stable_q;
      if (sync2_q == stable_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         stable_d = ~stable_q;
         cnt_d    = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
      // Edge detect against the previous stable level; releases are dropped.
      press_d = stable_q & ~prev_q;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         prev_q   <= 1'b0;
         press_q  <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= raw;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         prev_q   <= stable_q;
         press_q  <= press_d;
         cnt_q    <= cnt_d;
      end
   end

   assign press = press_q;

endmodule

// File: rtl/main_menu_controller.sv
// Main-menu cursor navigation and launch handshake; sel feeds the VGA
// renderer's metadata bits and mode captures the launched option.
module main_menu_controller
   import main_menu_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int CNT_W           = 18
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             btn_up,
   input  logic             btn_down,
   input  logic             btn_left,
   input  logic             btn_right,
   input  logic             btn_select,
   input  logic             start_ack,
   input  logic             game_done,
   output logic [SEL_W-1:0] sel,
   output logic             menu_visible,
   output logic             start_req,
   output logic [SEL_W-1:0] mode,
   output logic [1:0]       state
);

   logic [NUM_BTNS-1:0] raw_btn, press;

   assign raw_btn[BTN_UP]     = btn_up;
   assign raw_btn[BTN_DOWN]   = btn_down;
   assign raw_btn[BTN_LEFT]   = btn_left;
   assign raw_btn[BTN_RIGHT]  = btn_right;
   assign raw_btn[BTN_SELECT] = btn_select;

   for (genvar i = 0; i < NUM_BTNS; i++) begin : g_deb
      button_debouncer #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .CNT_W          (CNT_W)
      ) u_deb (
         .clock (clock),
         .resetn(resetn),
         .raw   (raw_btn[i]),
         .press (press[i])
      );
   end

   state_e state_q, state_d;
   opt_e   sel_q, sel_d;
   opt_e   mode_q, mode_d;
   logic   start_req_q, start_req_d;
   logic   menu_visible_q, menu_visible_d;

   always_comb begin
      state_d        = state_q;
      sel_d          = sel_q;
      mode_d         = mode_q;
      start_req_d    = start_req_q;
      menu_visible_d = menu_visible_q;
      case (state_q)
         MENU: begin
            menu_visible_d = 1'b1;
            start_req_d    = 1'b0;
            // Priority chain: only the highest-priority press acts.
            if (press[BTN_SELECT]) begin
               mode_d      = sel_q;
               start_req_d = 1'b1;
               state_d     = LAUNCH;
            end else if (press[BTN_UP]) begin
               case (sel_q)
                  OPT_PLAY_1P:      sel_d = OPT_PLAY_2P;
                  OPT_PLAY_ENDLESS: sel_d = OPT_PLAY_1P;
                  OPT_PLAY_2P:      sel_d = OPT_PLAY_ENDLESS;
                  OPT_TOP_1P:       sel_d = OPT_TOP_ENDLESS;
                  OPT_TOP_ENDLESS:  sel_d = OPT_TOP_1P;
                  default:          sel_d = OPT_PLAY_1P;
               endcase
            end else if (press[BTN_DOWN]) begin
               case (sel_q)
                  OPT_PLAY_1P:      sel_d = OPT_PLAY_ENDLESS;
                  OPT_PLAY_ENDLESS: sel_d = OPT_PLAY_2P;
                  OPT_PLAY_2P:      sel_d = OPT_PLAY_1P;
                  OPT_TOP_1P:       sel_d = OPT_TOP_ENDLESS;
                  OPT_TOP_ENDLESS:  sel_d = OPT_TOP_1P;
                  default:          sel_d = OPT_PLAY_1P;
               endcase
            end else if (press[BTN_LEFT]) begin
               case (sel_q)
                  OPT_TOP_1P:      sel_d = OPT_PLAY_1P;
                  OPT_TOP_ENDLESS: sel_d = OPT_PLAY_ENDLESS;
                  default:         sel_d = sel_q;
               endcase
            end else if (press[BTN_RIGHT]) begin
               case (sel_q)
                  OPT_PLAY_1P:      sel_d = OPT_TOP_1P;
                  OPT_PLAY_ENDLESS: sel_d = OPT_TOP_ENDLESS;
                  OPT_PLAY_2P:      sel_d = OPT_TOP_ENDLESS;
                  default:          sel_d = sel_q;
               endcase
            end
         end
         LAUNCH: begin
            menu_visible_d = 1'b1;
            start_req_d    = 1'b1;
            if (start_ack) begin
               start_req_d    = 1'b0;
               menu_visible_d = 1'b0;
               state_d        = RUNNING;
            end
         end
         RUNNING: begin
            menu_visible_d = 1'b0;
            start_req_d    = 1'b0;
            if (game_done) begin
               menu_visible_d = 1'b1;
               state_d        = MENU;
            end
         end
         default: begin
            state_d        = MENU;
            menu_visible_d = 1'b1;
            start_req_d    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q        <= MENU;
         sel_q          <= OPT_PLAY_1P;
         mode_q         <= OPT_PLAY_1P;
         start_req_q    <= 1'b0;
         menu_visible_q <= 1'b1;
      end else begin
         state_q        <= state_d;
         sel_q          <= sel_d;
         mode_q         <= mode_d;
         start_req_q    <= start_req_d;
         menu_visible_q <= menu_visible_d;
      end
   end

   assign sel          = sel_q;
   assign mode         = mode_q;
   assign start_req    = start_req_q;
   assign menu_visible = menu_visible_q;
   assign state        = state_q;

endmodule

// File: tb/tb_main_menu_controller.sv
// Directed bench for main_menu_controller with a 4-cycle debounce window.
module tb_main_menu_controller;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic [4:0] btns = 5'b0;   // 0 up, 1 down, 2 left, 3 right, 4 select
   logic       start_ack = 1'b0;
   logic       game_done = 1'b0;
   logic [2:0] sel, mode;
   logic       menu_visible, start_req;
   logic [1:0] state;

   int checks = 0;
   int errors = 0;

   main_menu_controller #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
      .clock       (clock),
      .resetn      (resetn),
      .btn_up      (btns[0]),
      .btn_down    (btns[1]),
      .btn_left    (btns[2]),
      .btn_right   (btns[3]),
      .btn_select  (btns[4]),
      .start_ack   (start_ack),
      .game_done   (game_done),
      .sel         (sel),
      .menu_visible(menu_visible),
      .start_req   (start_req),
      .mode        (mode),
      .state       (state)
   );

   always #5 clock = ~clock;

   // Hold a button long enough to debounce, release, and let it settle low.
   task automatic press(input int idx);
      @(negedge clock) btns[idx] = 1'b1;
      repeat (10) @(negedge clock);
      btns[idx] = 1'b0;
      repeat (10) @(negedge clock);
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      repeat (2) @(negedge clock);
      checks++;
      if (sel !== 3'd0 || mode !== 3'd0 || start_req !== 1'b0 ||
          menu_visible !== 1'b1 || state !== 2'd0) begin
         errors++;
         $display("FAIL reset: sel=%0d mode=%0d req=%0b vis=%0b st=%0d want 0 0 0 1 0",
                  sel, mode, start_req, menu_visible, state);
      end
      resetn = 1'b1;
      repeat (2) @(negedge clock);
   endtask

   task automatic test_down_hold();
      logic early_ok;
      early_ok = 1'b1;
      @(negedge clock) btns[1] = 1'b1;
      // Edges k..k+6 must leave sel at 0.
      for (int i = 0; i < 7; i++) begin
         @(negedge clock);
         if (sel !== 3'd0) early_ok = 1'b0;
      end
      checks++;
      if (!early_ok) begin
         errors++;
         $display("FAIL down_latency_early: sel changed before edge k+7, now %0d want 0", sel);
      end
      @(negedge clock);
      checks++;
      if (sel !== 3'd1) begin
         errors++;
         $display("FAIL down_latency_k7: sel=%0d want 1", sel);
      end
      repeat (5) @(negedge clock);
      checks++;
      if (sel !== 3'd1) begin
         errors++;
         $display("FAIL down_held: sel=%0d want 1", sel);
      end
      btns[1] = 1'b0;
      repeat (10) @(negedge clock);
      checks++;
      if (sel !== 3'd1) begin
         errors++;
         $display("FAIL down_release: sel=%0d want 1", sel);
      end
      press(1);
      checks++;
      if (sel !== 3'd2) begin
         errors++;
         $display("FAIL down_second: sel=%0d want 2", sel);
      end
      press(1);
      checks++;
      if (sel !== 3'd0) begin
         errors++;
         $display("FAIL down_wrap: sel=%0d want 0", sel);
      end
   endtask

   task automatic test_nav();
      press(1);
      press(1);   // sel = 2
      press(3);
      checks++;
      if (sel !== 3'd4) begin
         errors++;
         $display("FAIL right_from_2: sel=%0d want 4", sel);
      end
      press(3);
      checks++;
      if (sel !== 3'd4) begin
         errors++;
         $display("FAIL right_in_right_col: sel=%0d want 4", sel);
      end
      press(2);
      checks++;
      if (sel !== 3'd1) begin
         errors++;
         $display("FAIL left_from_4: sel=%0d want 1", sel);
      end
      press(0);
      checks++;
      if (sel !== 3'd0) begin
         errors++;
         $display("FAIL up_from_1: sel=%0d want 0", sel);
      end
      press(0);
      checks++;
      if (sel !== 3'd2) begin
         errors++;
         $display("FAIL up_wrap: sel=%0d want 2", sel);
      end
   endtask

   task automatic test_glitch();
      logic [6:0] bounce;
      @(negedge clock) btns[0] = 1'b1;
      repeat (3) @(negedge clock);
      btns[0] = 1'b0;
      repeat (12) @(negedge clock);
      checks++;
      if (sel !== 3'd2) begin
         errors++;
         $display("FAIL glitch_3cyc: sel=%0d want 2", sel);
      end
      bounce = 7'b1111101;   // applied LSB first: 1,0,1,1,1,1,1
      for (int i = 0; i < 7; i++) begin
         btns[0] = bounce[i];
         @(negedge clock);
      end
      repeat (6) @(negedge clock);
      btns[0] = 1'b0;
      repeat (10) @(negedge clock);
      checks++;
      if (sel !== 3'd1) begin
         errors++;
         $display("FAIL bounce_one_event: sel=%0d want 1", sel);
      end
   endtask

   task automatic test_select_priority();
      @(negedge clock) btns = 5'b10010;
      repeat (10) @(negedge clock);
      btns = 5'b0;
      repeat (10) @(negedge clock);
      checks++;
      if (mode !== 3'd1 || start_req !== 1'b1 || state !== 2'd1 ||
          sel !== 3'd1 || menu_visible !== 1'b1) begin
         errors++;
         $display("FAIL select_priority: mode=%0d req=%0b st=%0d sel=%0d vis=%0b want 1 1 1 1 1",
                  mode, start_req, state, sel, menu_visible);
      end
   endtask

   task automatic test_launch();
      press(1);
      @(negedge clock) game_done = 1'b1;
      @(negedge clock) game_done = 1'b0;
      checks++;
      if (sel !== 3'd1 || state !== 2'd1 || start_req !== 1'b1) begin
         errors++;
         $display("FAIL launch_ignore: sel=%0d st=%0d req=%0b want 1 1 1", sel, state, start_req);
      end
      start_ack = 1'b1;
      game_done = 1'b1;
      @(negedge clock) start_ack = 1'b0;
      game_done = 1'b0;
      checks++;
      if (start_req !== 1'b0 || menu_visible !== 1'b0 || state !== 2'd2) begin
         errors++;
         $display("FAIL launch_ack: req=%0b vis=%0b st=%0d want 0 0 2", start_req, menu_visible, state);
      end
      repeat (3) @(negedge clock);
      checks++;
      if (state !== 2'd2 || menu_visible !== 1'b0) begin
         errors++;
         $display("FAIL running_hold: st=%0d vis=%0b want 2 0", state, menu_visible);
      end
      game_done = 1'b1;
      @(negedge clock) game_done = 1'b0;
      checks++;
      if (state !== 2'd0 || menu_visible !== 1'b1 || sel !== 3'd1 || mode !== 3'd1) begin
         errors++;
         $display("FAIL game_done: st=%0d vis=%0b sel=%0d mode=%0d want 0 1 1 1",
                  state, menu_visible, sel, mode);
      end
      start_ack = 1'b1;
      @(negedge clock) start_ack = 1'b0;
      checks++;
      if (state !== 2'd0 || start_req !== 1'b0) begin
         errors++;
         $display("FAIL stray_ack: st=%0d req=%0b want 0 0", state, start_req);
      end
   endtask

   task automatic test_async_reset();
      press(3);   // sel 1 -> 4
      press(4);
      @(negedge clock) start_ack = 1'b1;
      @(negedge clock) start_ack = 1'b0;
      checks++;
      if (sel !== 3'd4 || mode !== 3'd4 || state !== 2'd2) begin
         errors++;
         $display("FAIL pre_reset: sel=%0d mode=%0d st=%0d want 4 4 2", sel, mode, state);
      end
      #2 resetn = 1'b0;
      #1;
      checks++;
      if (sel !== 3'd0 || mode !== 3'd0 || menu_visible !== 1'b1 ||
          start_req !== 1'b0 || state !== 2'd0) begin
         errors++;
         $display("FAIL async_reset: sel=%0d mode=%0d vis=%0b req=%0b st=%0d want 0 0 1 0 0",
                  sel, mode, menu_visible, start_req, state);
      end
      @(negedge clock) resetn = 1'b1;
   endtask

   initial begin
      test_reset();
      test_down_hold();
      test_nav();
      test_glitch();
      test_select_priority();
      test_launch();
      test_async_reset();
      repeat (2) @(negedge clock);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
